// File: rtl/ej7_logic_core_if.sv
// Signal bundle for ej7_logic_core: two function-group input sets and six registered outputs.
// The names follow the original exercise, so Y/y and Z/z are different signals.
interface ej7_logic_core_if;
  logic A;
  logic B;
  logic C;
  logic D;
  logic x;
  logic y;
  logic z;
  logic Y;
  logic Z;
  logic Yb;
  logic Zb;
  logic F2;
  logic F2b;

  modport master (
    output A, B, C, D, x, y, z,
    input  Y, Z, Yb, Zb, F2, F2b
  );

  modport slave (
    input  A, B, C, D, x, y, z,
    output Y, Z, Yb, Zb, F2, F2b
  );
endinterface

// File: rtl/ej7_logic_core.sv
// Registered logic block: Y/Z of {A,B,C,D}, odd parity F2 of {x,y,z}, plus complements.
// Each complement is its own minimal SOP with its own flop, so it has the same 1-cycle latency.
module ej7_logic_core (
  input logic              clk,
  input logic              reset,
  ej7_logic_core_if.slave  bus
);

  logic y_d;
  logic z_d;
  logic yb_d;
  logic zb_d;
  logic f2_d;
  logic f2b_d;

  always_comb begin
    y_d   = (~bus.A & bus.D) | (bus.A & bus.B) | (~bus.C & bus.D);
    z_d   = (~bus.A & ~bus.D) | (bus.A & bus.C);
    // Y' = sum of minterms 0,2,4,6,8,10,11; Z' = sum of minterms 1,3,5,7,8,9,12,13
    yb_d  = (~bus.A & ~bus.D) | (~bus.B & ~bus.D) | (bus.A & ~bus.B & bus.C);
    zb_d  = (~bus.A & bus.D) | (bus.A & ~bus.C);
    f2_d  = bus.x ^ bus.y ^ bus.z;
    f2b_d = ~(bus.x ^ bus.y ^ bus.z);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.Y   <= 1'b0;
      bus.Z   <= 1'b0;
      bus.F2  <= 1'b0;
      bus.Yb  <= 1'b1;
      bus.Zb  <= 1'b1;
      bus.F2b <= 1'b1;
    end else begin
      bus.Y   <= y_d;
      bus.Z   <= z_d;
      bus.F2  <= f2_d;
      bus.Yb  <= yb_d;
      bus.Zb  <= zb_d;
      bus.F2b <= f2b_d;
    end
  end

endmodule

// File: tb/tb_ej7_logic_core.sv
// Self-checking bench for ej7_logic_core: the minterm-table model feeds a scoreboard,
// and the bench also checks the reset, latency and independence cases.
module tb_ej7_logic_core;

  localparam logic [15:0] Y_TT  = 16'hF2AA;
  localparam logic [15:0] Z_TT  = 16'hCC55;
  localparam logic [7:0]  F2_TT = 8'h96;

  typedef struct packed {
    logic y;
    logic z;
    logic f2;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  ej7_logic_core_if bus ();

  ej7_logic_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] m, input logic [2:0] n);
    exp_t e;
    e.y  = Y_TT[m];
    e.z  = Z_TT[m];
    e.f2 = F2_TT[n];
    return e;
  endfunction

  task automatic drive(input logic [3:0] m, input logic [2:0] n);
    bus.A = m[3];
    bus.B = m[2];
    bus.C = m[1];
    bus.D = m[0];
    bus.x = n[2];
    bus.y = n[1];
    bus.z = n[0];
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".Y"},   bus.Y,   e.y);
    chk({tag, ".Yb"},  bus.Yb,  ~e.y);
    chk({tag, ".Z"},   bus.Z,   e.z);
    chk({tag, ".Zb"},  bus.Zb,  ~e.z);
    chk({tag, ".F2"},  bus.F2,  e.f2);
    chk({tag, ".F2b"}, bus.F2b, ~e.f2);
  endtask

  task automatic chk_reset_vals(input string tag);
    exp_t e;
    e = '0;
    chk_all(tag, e);
  endtask

  // Drive one vector at the falling edge and compare just after the next rising edge.
  task automatic step(input logic [3:0] m, input logic [2:0] n, input string tag);
    exp_t e;
    @(negedge clk);
    drive(m, n);
    sb.push_back(model(m, n));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk_all(tag, e);
    end
  endtask

  initial begin
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(4'b1101, 3'b111);

    // Reset held low with active inputs and a running clock.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    reset = 1'b1;

    // Exhaustive group 1 with a changing group 2 input.
    for (int i = 0; i < 16; i++) step(4'(i), 3'(i % 8), "g1");

    // Exhaustive group 2.
    for (int i = 0; i < 8; i++) step(4'(15 - i), 3'(i), "g2");

    // Spot checks with explicit constants.
    step(4'b0000, 3'b000, "spot0000");
    chk("spot0000.Yc", bus.Y, 1'b0);
    chk("spot0000.Zc", bus.Z, 1'b1);
    step(4'b0011, 3'b000, "spot0011");
    chk("spot0011.Yc", bus.Y, 1'b1);
    chk("spot0011.Zc", bus.Z, 1'b0);
    step(4'b1011, 3'b000, "spot1011");
    chk("spot1011.Yc", bus.Y, 1'b0);
    chk("spot1011.Zc", bus.Z, 1'b1);
    step(4'b1000, 3'b000, "spot1000");
    chk("spot1000.Yc", bus.Y, 1'b0);
    chk("spot1000.Zc", bus.Z, 1'b0);

    // Independence: hold one group and sweep the other.
    for (int i = 0; i < 8; i++) begin
      step(4'b1101, 3'(i), "hold_g1");
      chk("hold_g1.Ystable", bus.Y, 1'b1);
      chk("hold_g1.Zstable", bus.Z, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 3'b111, "hold_g2");
      chk("hold_g2.F2stable", bus.F2, 1'b1);
    end

    // Latency: change the inputs just before an edge.
    step(4'b0000, 3'b000, "lat_pre");
    @(negedge clk);
    #3;
    drive(4'b1101, 3'b111);
    #1;
    chk("lat_before.Y", bus.Y, 1'b0);
    chk("lat_before.Z", bus.Z, 1'b1);
    chk("lat_before.F2", bus.F2, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_after.Y", bus.Y, 1'b1);
    chk("lat_after.Z", bus.Z, 1'b0);
    chk("lat_after.F2", bus.F2, 1'b1);
    chk("lat_after.Yb", bus.Yb, 1'b0);

    // Reset asserted between edges acts without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    @(posedge clk);
    #1;
    chk_reset_vals("rst_async_hold");

    // Release at the falling edge: outputs keep reset values until the next rising edge.
    @(negedge clk);
    reset = 1'b1;
    drive(4'b0011, 3'b001);
    #1;
    chk_reset_vals("rst_release_pre");
    @(posedge clk);
    #1;
    e = model(4'b0011, 3'b001);
    chk_all("rst_release_post", e);

    // A random run to finish.
    for (int i = 0; i < 40; i++) step(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), "rand");

    if (sb.size() != 0) chk("sb_leftover", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
